// File: rtl/console_mmio_pkg.sv
// Register map, address decode and STATUS word packing shared by the console/pass MMIO slave.
// Pure constants and functions: no latency, no flow control.
package console_mmio_pkg;

  localparam logic [31:0] DEF_CONSOLE_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_BASE    = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;
  localparam int          DEF_FIFO_DEPTH   = 16;

  localparam logic [31:0] CONSOLE_SPAN = 32'd8;
  localparam logic [31:0] PASS_SPAN    = 32'd4;
  localparam logic [31:0] STATUS_OFF   = 32'd4;

  localparam int ST_EMPTY_BIT  = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_IRQ_EN_BIT = 2;
  localparam int ST_COUNT_LSB  = 8;

  typedef enum logic [1:0] {T_TXDATA, T_STATUS, T_PASS, T_NONE} target_t;

  // Offset-from-base compare keeps every address bit significant and handles any base alignment.
  function automatic target_t decode_target(input logic [31:0] addr,
                                            input logic [31:0] console_base,
                                            input logic [31:0] pass_base);
    logic [31:0] c_off;
    logic [31:0] p_off;
    c_off = addr - console_base;
    p_off = addr - pass_base;
    if (c_off < CONSOLE_SPAN)
      return (c_off >= STATUS_OFF) ? T_STATUS : T_TXDATA;
    else if (p_off < PASS_SPAN)
      return T_PASS;
    else
      return T_NONE;
  endfunction

  function automatic logic [31:0] status_word(input logic [7:0] count, input logic irq_en,
                                              input logic full, input logic empty);
    logic [31:0] w;
    w = '0;
    w[ST_COUNT_LSB +: 8] = count;
    w[ST_IRQ_EN_BIT]     = irq_en;
    w[ST_FULL_BIT]       = full;
    w[ST_EMPTY_BIT]      = empty;
    return w;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO; head is the stored entry at the read pointer, push visible one edge later.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module console_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi4lite_console_mmio.sv
// AXI4-lite MMIO slave: console TX FIFO + sticky pass flag; CONSOLE_IRQ_EN adds console_irq/irq_en.
// bvalid/rvalid one edge after the address+data latches fill; TXDATA writes stall while the FIFO is full.
module axi4lite_console_mmio
  import console_mmio_pkg::*;
#(
  parameter logic [31:0] CONSOLE_BASE = DEF_CONSOLE_BASE,
  parameter logic [31:0] PASS_BASE    = DEF_PASS_BASE,
  parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC,
  parameter int          FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tests_passed,
  output logic        addr_err
`ifdef CONSOLE_IRQ_EN
  ,
  output logic        console_irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          aw_latched;
  logic          w_latched;
  logic          ar_latched;
  target_t       aw_tgt;
  target_t       ar_tgt;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          irq_en;
  logic          tx_push_req;
  logic          wr_stall;
  logic          wr_fire;
  logic          rd_fire;
  logic [31:0]   rd_val;

  assign mem_axi_awready = !reset && mem_axi_awvalid && !aw_latched;
  assign mem_axi_wready  = !reset && mem_axi_wvalid && !w_latched;
  assign mem_axi_arready = !reset && mem_axi_arvalid && !ar_latched && !mem_axi_rvalid;

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_head;
  assign fifo_pop = tx_valid && tx_ready;

  // A pop in the same cycle frees the slot, so a full FIFO only stalls when nothing drains.
  assign tx_push_req = (aw_tgt == T_TXDATA) && wstrb_q[0];
  assign wr_stall    = tx_push_req && fifo_full && !fifo_pop;
  assign wr_fire     = aw_latched && w_latched && !mem_axi_bvalid && !wr_stall;
  assign fifo_push   = wr_fire && tx_push_req;
  assign rd_fire     = ar_latched && !mem_axi_rvalid;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (wdata_q[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_comb begin
    rd_val = '0;
    case (ar_tgt)
      T_STATUS: rd_val = status_word(8'(fifo_count), irq_en, fifo_full, fifo_empty);
      T_PASS:   rd_val = {31'b0, tests_passed};
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_latched     <= 1'b0;
      aw_tgt         <= T_NONE;
      w_latched      <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      mem_axi_bvalid <= 1'b0;
      tests_passed   <= 1'b0;
    end else begin
      if (mem_axi_awready) begin
        aw_latched <= 1'b1;
        aw_tgt     <= decode_target(mem_axi_awaddr, CONSOLE_BASE, PASS_BASE);
      end else if (wr_fire) begin
        aw_latched <= 1'b0;
      end
      if (mem_axi_wready) begin
        w_latched <= 1'b1;
        wdata_q   <= mem_axi_wdata;
        wstrb_q   <= mem_axi_wstrb;
      end else if (wr_fire) begin
        w_latched <= 1'b0;
      end
      if (wr_fire)
        mem_axi_bvalid <= 1'b1;
      else if (mem_axi_bready)
        mem_axi_bvalid <= 1'b0;
      if (wr_fire && aw_tgt == T_PASS && wdata_q == PASS_MAGIC && wstrb_q == 4'hF)
        tests_passed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_latched     <= 1'b0;
      ar_tgt         <= T_NONE;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= '0;
    end else begin
      if (mem_axi_arready) begin
        ar_latched <= 1'b1;
        ar_tgt     <= decode_target(mem_axi_araddr, CONSOLE_BASE, PASS_BASE);
      end else if (rd_fire) begin
        ar_latched <= 1'b0;
      end
      if (rd_fire) begin
        mem_axi_rvalid <= 1'b1;
        mem_axi_rdata  <= rd_val;
      end else if (mem_axi_rvalid && mem_axi_rready) begin
        mem_axi_rvalid <= 1'b0;
        mem_axi_rdata  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      addr_err <= 1'b0;
    else if ((wr_fire && aw_tgt == T_NONE) || (rd_fire && ar_tgt == T_NONE))
      addr_err <= 1'b1;
  end

`ifdef CONSOLE_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en      <= 1'b0;
      console_irq <= 1'b0;
    end else begin
      if (wr_fire && aw_tgt == T_STATUS && wstrb_q[0])
        irq_en <= wdata_q[ST_IRQ_EN_BIT];
      console_irq <= irq_en && fifo_empty;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_axi4lite_console_mmio.sv
// Bench for axi4lite_console_mmio: register-map vector table, directed corner sequences,
// then random traffic against a queue-based model of the console stream and sticky flags.
module tb_axi4lite_console_mmio;

  localparam logic [31:0] CB    = 32'h1000_0000;
  localparam logic [31:0] PB    = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;
`ifdef CONSOLE_IRQ_EN
  localparam logic [31:0] IRQ_ST = 32'h4;
`else
  localparam logic [31:0] IRQ_ST = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        tx_valid, tx_ready, tests_passed, addr_err;
  logic [7:0]  tx_data;
  logic        tx_rand_en, tx_rand_bit, tx_ready_man;
`ifdef CONSOLE_IRQ_EN
  logic        console_irq;
`endif

  assign tx_ready = tx_rand_en ? tx_rand_bit : tx_ready_man;

  axi4lite_console_mmio dut (
    .clk (clk), .reset (reset),
    .mem_axi_awvalid (awvalid), .mem_axi_awready (awready), .mem_axi_awaddr (awaddr),
    .mem_axi_wvalid (wvalid), .mem_axi_wready (wready), .mem_axi_wdata (wdata), .mem_axi_wstrb (wstrb),
    .mem_axi_bvalid (bvalid), .mem_axi_bready (bready),
    .mem_axi_arvalid (arvalid), .mem_axi_arready (arready), .mem_axi_araddr (araddr),
    .mem_axi_rvalid (rvalid), .mem_axi_rready (rready), .mem_axi_rdata (rdata),
    .tx_valid (tx_valid), .tx_ready (tx_ready), .tx_data (tx_data),
    .tests_passed (tests_passed), .addr_err (addr_err)
`ifdef CONSOLE_IRQ_EN
    , .console_irq (console_irq)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Stream monitor: a byte leaves at the next posedge when valid && ready are both high here.
  always @(negedge clk) begin
    if (reset) got_q.delete();
    else if (tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  initial begin
    tx_rand_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1 tx_rand_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    bit aw_done = 0;
    bit w_done = 0;
    awaddr = a; wdata = d; wstrb = s;
    for (int c = 0; c < 64 && !(aw_done && w_done); c++) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      #1;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk);
      #1;
    end
    awvalid = 0; wvalid = 0;
    check("aw_w_accept", 32'(aw_done && w_done), 32'd1);
  endtask

  // Returns the number of edges until bvalid was seen (-1 on timeout); bready high consumes it.
  task automatic wait_b(input int max_cyc, output int cyc);
    cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (bvalid) begin cyc = c; break; end
      step();
    end
    if (cyc >= 0 && bready) step();
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output int cyc);
    send_aw_w(a, d, s, aw_dly, w_dly);
    wait_b(60, cyc);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output int cyc);
    bit done = 0;
    araddr = a;
    for (int c = 0; c < 64 && !done; c++) begin
      arvalid = 1;
      #1;
      if (arready) done = 1;
      step();
    end
    arvalid = 0;
    check("ar_accept", 32'(done), 32'd1);
    cyc = -1;
    data = '0;
    for (int c = 0; c < 64; c++) begin
      if (rvalid) begin cyc = c; data = rdata; break; end
      step();
    end
    check("r_arrive", 32'(cyc >= 0), 32'd1);
    if (cyc >= 0 && rready) step();
  endtask

  task automatic check_idle(input string p);
    check({p, "_awready"}, 32'(awready), 0);
    check({p, "_wready"}, 32'(wready), 0);
    check({p, "_bvalid"}, 32'(bvalid), 0);
    check({p, "_arready"}, 32'(arready), 0);
    check({p, "_rvalid"}, 32'(rvalid), 0);
    check({p, "_rdata"}, rdata, 0);
    check({p, "_tx_valid"}, 32'(tx_valid), 0);
    check({p, "_tx_data"}, 32'(tx_data), 0);
    check({p, "_tests_passed"}, 32'(tests_passed), 0);
    check({p, "_addr_err"}, 32'(addr_err), 0);
  endtask

  task automatic drain_compare(input string p);
    tx_rand_en = 0;
    tx_ready_man = 1;
    for (int t = 0; t < 300 && got_q.size() < exp_q.size(); t++) step();
    repeat (3) step();
    check({p, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({p, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  function automatic logic [31:0] exp_status(input int cnt);
    return (32'(cnt) << 8) | (cnt == 16 ? 32'h2 : 32'h0) | (cnt == 0 ? 32'h1 : 32'h0);
  endfunction

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_tp;
  } vec_t;

  vec_t        tbl[15];
  logic [31:0] rv, d, a;
  logic [3:0]  s;
  int          cyc, op, cnt;
  bit          m_tp, m_err, stable;

  initial begin
    reset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    tx_rand_en = 0; tx_ready_man = 0;
    repeat (2) step();
    apply_reset();
    check_idle("reset");

    // Register-map vectors from a clean reset, console stream held off.
    tbl[0]  = '{0, CB + 4, 0, 0, 32'h1, 0, 0};
    tbl[1]  = '{1, CB, 32'h1AB, 4'hE, 0, 0, 0};
    tbl[2]  = '{0, CB + 4, 0, 0, 32'h1, 0, 0};
    tbl[3]  = '{1, CB, 32'h42, 4'h1, 0, 0, 0};
    tbl[4]  = '{0, CB + 4, 0, 0, 32'h100, 0, 0};
    tbl[5]  = '{0, CB, 0, 0, 32'h0, 0, 0};
    tbl[6]  = '{1, PB, MAGIC, 4'h7, 0, 0, 0};
    tbl[7]  = '{0, PB, 0, 0, 32'h0, 0, 0};
    tbl[8]  = '{1, CB + 4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0};
    tbl[9]  = '{0, CB + 4, 0, 0, 32'h100 | IRQ_ST, 0, 0};
    tbl[10] = '{0, CB + 3, 0, 0, 32'h0, 0, 0};
    tbl[11] = '{0, PB + 4, 0, 0, 32'h0, 1, 0};
    tbl[12] = '{1, PB, MAGIC, 4'hF, 0, 1, 1};
    tbl[13] = '{0, PB, 0, 0, 32'h1, 1, 1};
    tbl[14] = '{0, CB - 4, 0, 0, 32'h0, 1, 1};
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, cyc);
        check("tbl_b_latency", 32'(cyc), 32'd1);
      end else begin
        axi_read(tbl[i].addr, rv, cyc);
        check("tbl_rdata", rv, tbl[i].exp_rdata);
      end
      check("tbl_addr_err", 32'(addr_err), 32'(tbl[i].exp_err));
      check("tbl_tests_passed", 32'(tests_passed), 32'(tbl[i].exp_tp));
    end

    // AW first, W two cycles later; one byte out.
    apply_reset();
    tx_ready_man = 1;
    axi_write(CB, 32'h41, 4'hF, 0, 2, cyc);
    check("t1_b_latency", 32'(cyc), 32'd1);
    repeat (4) step();
    check("t1_nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t1_byte", 32'(got_q[0]), 32'h41);

    // Fill to full, the 17th write stalls until the stream drains.
    apply_reset();
    tx_ready_man = 0;
    for (int i = 0; i < 16; i++) begin
      d = 32'($urandom);
      axi_write(CB, d, 4'h1, 0, 0, cyc);
      check("t2_b_latency", 32'(cyc), 32'd1);
      exp_q.push_back(d[7:0]);
    end
    d = 32'h5A;
    send_aw_w(CB, d, 4'h1, 0, 0);
    wait_b(10, cyc);
    check("t2_stall_no_b", 32'(cyc), 32'hFFFF_FFFF);
    axi_read(CB + 4, rv, cyc);
    check("t2_status_full", rv, exp_status(16));
    tx_ready_man = 1;
    wait_b(10, cyc);
    check("t2_unstall_b", 32'(cyc), 32'd1);
    exp_q.push_back(d[7:0]);
    drain_compare("t2");

    // Pass register: magic sets, other values ignored, reset clears.
    apply_reset();
    axi_write(PB, MAGIC, 4'hF, 1, 0, cyc);
    check("t3_tp_set", 32'(tests_passed), 32'd1);
    axi_read(PB, rv, cyc);
    check("t3_read", rv, 32'd1);
    axi_write(PB, 32'd5, 4'hF, 0, 0, cyc);
    check("t3_tp_sticky", 32'(tests_passed), 32'd1);
    apply_reset();
    check("t3_tp_reset", 32'(tests_passed), 32'd0);

    // STATUS with 3 queued bytes, response held under rready=0.
    apply_reset();
    tx_ready_man = 0;
    for (int i = 0; i < 3; i++) axi_write(CB, 32'(i), 4'h1, 0, 0, cyc);
    rready = 0;
    axi_read(CB + 4, rv, cyc);
    check("t4_rdata", rv, 32'h0000_0300);
    stable = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!rvalid || rdata !== 32'h300) stable = 0;
    end
    check("t4_hold_stable", 32'(stable), 32'd1);
    rready = 1;
    step();
    check("t4_r_consumed", 32'(rvalid), 32'd0);

    // Out-of-window write: response, addr_err, no FIFO change.
    apply_reset();
    axi_write(CB, 32'h33, 4'h1, 0, 0, cyc);
    axi_write(32'h3000_0000, 32'h77, 4'hF, 0, 0, cyc);
    check("t5_b", 32'(cyc), 32'd1);
    check("t5_addr_err", 32'(addr_err), 32'd1);
    axi_read(CB + 4, rv, cyc);
    check("t5_count", rv, exp_status(1));

    // Reset with a W latched and 5 bytes queued.
    apply_reset();
    axi_write(PB, MAGIC, 4'hF, 0, 0, cyc);
    axi_read(32'h3000_0000, rv, cyc);
    for (int i = 0; i < 5; i++) axi_write(CB, 32'h60 + 32'(i), 4'h1, 0, 0, cyc);
    wvalid = 1; wdata = 32'h99; wstrb = 4'h1;
    #1 check("t6_w_taken", 32'(wready), 32'd1);
    step();
    wvalid = 0;
    apply_reset();
    check_idle("t6");
    axi_read(CB + 4, rv, cyc);
    check("t6_count", rv, exp_status(0));
    awaddr = CB; awvalid = 1;
    #1 check("t6_aw_taken", 32'(awready), 32'd1);
    step();
    awvalid = 0;
    wait_b(4, cyc);
    check("t6_stale_w_dropped", 32'(cyc), 32'hFFFF_FFFF);
    wvalid = 1; wdata = 32'h77; wstrb = 4'h1;
    step();
    wvalid = 0;
    wait_b(10, cyc);
    check("t6_b_after_w", 32'(cyc >= 0), 32'd1);
    exp_q.push_back(8'h77);
    drain_compare("t6");

    // Random traffic against the model.
    apply_reset();
    m_tp = 0; m_err = 0;
    tx_rand_en = 1;
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          d = 32'($urandom); s = 4'($urandom_range(0, 15));
          axi_write(CB + 32'($urandom_range(0, 3)), d, s, $urandom_range(0, 2), $urandom_range(0, 2), cyc);
          check("rnd_tx_b", 32'(cyc >= 0), 32'd1);
          if (s[0]) exp_q.push_back(d[7:0]);
        end
        1: begin
          d = ($urandom_range(0, 1) == 1) ? MAGIC : 32'($urandom);
          s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
          axi_write(PB, d, s, $urandom_range(0, 2), $urandom_range(0, 2), cyc);
          if (d == MAGIC && s == 4'hF) m_tp = 1;
        end
        2: begin
          axi_read(PB, rv, cyc);
          check("rnd_pass_rd", rv, 32'(m_tp));
        end
        3: begin
          a = 32'h4000_0000 | (32'($urandom) & 32'h0FFF_FFFF);
          if ($urandom_range(0, 1) == 1) axi_write(a, 32'($urandom), 4'hF, 0, 1, cyc);
          else begin
            axi_read(a, rv, cyc);
            check("rnd_bad_rdata", rv, 32'h0);
          end
          m_err = 1;
        end
        4: begin
          tx_rand_en = 0; tx_ready_man = 0;
          axi_read(CB + 4, rv, cyc);
          cnt = exp_q.size() - got_q.size();
          check("rnd_status", rv, exp_status(cnt));
          tx_rand_en = 1;
        end
        default: begin
          axi_read(CB + 32'($urandom_range(0, 3)), rv, cyc);
          check("rnd_txdata_rd", rv, 32'h0);
        end
      endcase
      check("rnd_addr_err", 32'(addr_err), 32'(m_err));
      check("rnd_tests_passed", 32'(tests_passed), 32'(m_tp));
    end
    drain_compare("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
